// File: rtl/mod_counter_if.sv
// rtl/mod_counter_if.sv - control/status bundle for mod_counter
//
// Purpose: groups the counter's control inputs and status outputs so they
// travel as one port. The driver side uses the master modport and the
// counter uses the slave modport.
//
// Signals:
//   en        count enable
//   up        direction, 1 = increment, 0 = decrement
//   oneshot   1 = stop at the terminal value instead of wrapping
//   load      synchronous load strobe
//   load_val  value written on load, WIDTH bits
//   cnt       registered count value, WIDTH bits
//   tc        registered terminal-count pulse
//   done      registered one-shot-finished flag
interface mod_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             oneshot;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             done;

  modport master (
    output en, up, oneshot, load, load_val,
    input  cnt, tc, done
  );

  modport slave (
    input  en, up, oneshot, load, load_val,
    output cnt, tc, done
  );
endinterface

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo up/down counter with one-shot and optional prescaler
//
// Purpose: counts 0..MODULUS-1 up or down, wrapping or stopping at the
// terminal value, with a registered terminal-count pulse and done flag.
//
// Ports:
//   clk   single clock, all state changes on its rising edge
//   rst   synchronous active-high reset
//   bus   mod_counter_if.slave (en, up, oneshot, load, load_val in;
//         cnt, tc, done out)
//
// Configuration macro: MOD_COUNTER_PRESCALE_EN
//   defined   -> a 16-bit prescaler makes one step every PRESCALE enabled cycles
//   undefined -> PRESCALE is ignored and every enabled RUN cycle is a step
module mod_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic          clk,
  input  logic          rst,
  mod_counter_if.slave  bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // MODULUS is 64-bit so MODULUS = 2**32 is representable; MODULUS-1 always fits.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt_q, cnt_n;
  logic             tc_q, tc_n;
  logic             done_q, done_n;

  logic             counting;
  logic             step;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] terminal;

  assign counting     = (state == RUN) && bus.en;
  assign load_clamped = (64'(bus.load_val) >= MODULUS) ? MAX_VAL : bus.load_val;
  assign terminal     = bus.up ? MAX_VAL : '0;

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0] ps_q, ps_n;

  // The step lands on the last enabled cycle of each interval.
  assign step = counting && (ps_q == PS_LAST);

  always_comb begin
    ps_n = ps_q;
    if (bus.load) begin
      ps_n = '0;
    end else if (step) begin
      ps_n = '0;
    end else if (counting) begin
      ps_n = ps_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_n;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign step            = counting;
`endif

  // Next-state and outputs; load outranks a step taken in the same cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    tc_n    = 1'b0;
    done_n  = done_q;
    if (bus.load) begin
      state_n = RUN;
      cnt_n   = load_clamped;
      done_n  = 1'b0;
    end else if (step) begin
      if (cnt_q == terminal) begin
        tc_n = 1'b1;
        if (bus.oneshot) begin
          state_n = HALT;
          done_n  = 1'b1;
        end else begin
          cnt_n = bus.up ? '0 : MAX_VAL;
        end
      end else begin
        cnt_n = bus.up ? cnt_q + 1'b1 : cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt_q  <= cnt_n;
      tc_q   <= tc_n;
      done_q <= done_n;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.tc   = tc_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - self-checking bench for mod_counter
module tb_mod_counter;

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int PS_EFF = 3;
`else
  localparam int PS_EFF = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(4)) if_a ();
  mod_counter_if #(.WIDTH(4)) if_b ();
  mod_counter_if #(.WIDTH(4)) if_p ();

  mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) dut_p (.clk(clk), .rst(rst), .bus(if_p));

  typedef struct {
    logic       rst;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up;
    logic       oneshot;
    logic [3:0] exp_cnt;
    logic       exp_tc;
    logic       exp_done;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic ld, input logic [3:0] lv, input logic e,
                     input logic u, input logic os, input logic [3:0] c, input logic t,
                     input logic d);
    vec_t v;
    v = '{rst: r, load: ld, load_val: lv, en: e, up: u, oneshot: os,
          exp_cnt: c, exp_tc: t, exp_done: d};
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int k;

    {if_a.en, if_a.up, if_a.oneshot, if_a.load, if_a.load_val} = '0;
    {if_b.en, if_b.up, if_b.oneshot, if_b.load, if_b.load_val} = '0;
    {if_p.en, if_p.up, if_p.oneshot, if_p.load, if_p.load_val} = '0;

    // Reset state
    rst = 1'b1;
    tick();
    chk("rst_a.cnt", if_a.cnt, 0);
    chk("rst_a.tc", if_a.tc, 0);
    chk("rst_a.done", if_a.done, 0);
    chk("rst_p.cnt", if_p.cnt, 0);
    rst = 1'b0;

    // Free-running up count over a full wrap, MODULUS=16
    if_a.en = 1'b1;
    if_a.up = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      chk($sformatf("wrap16[%0d].cnt", i), if_a.cnt, i % 16);
      chk($sformatf("wrap16[%0d].tc", i), if_a.tc, (i == 16) ? 1 : 0);
      tick();
    end

    // MODULUS=10 table: down wrap, load clamp, load-vs-step priority, one-shot down
    //   rst  ld lv    en  up  os  cnt  tc  done
    add(1, 0, 4'd0,  0, 0, 0, 4'd0, 0, 0);
    add(0, 1, 4'd0,  1, 0, 0, 4'd0, 0, 0);
    add(0, 0, 4'd0,  1, 0, 0, 4'd9, 1, 0);
    add(0, 0, 4'd0,  1, 0, 0, 4'd8, 0, 0);
    add(0, 0, 4'd0,  1, 0, 0, 4'd7, 0, 0);
    add(0, 1, 4'd12, 0, 0, 0, 4'd9, 0, 0);
    add(0, 1, 4'd10, 0, 0, 0, 4'd9, 0, 0);
    add(0, 1, 4'd15, 0, 0, 0, 4'd9, 0, 0);
    add(0, 1, 4'd3,  1, 1, 0, 4'd3, 0, 0);
    add(0, 0, 4'd0,  1, 1, 0, 4'd4, 0, 0);
    add(0, 0, 4'd0,  0, 1, 0, 4'd4, 0, 0);
    add(0, 1, 4'd9,  0, 1, 0, 4'd9, 0, 0);
    add(0, 0, 4'd0,  1, 1, 0, 4'd0, 1, 0);
    add(0, 0, 4'd0,  1, 1, 0, 4'd1, 0, 0);
    add(0, 0, 4'd0,  1, 0, 0, 4'd0, 0, 0);
    add(0, 0, 4'd0,  1, 0, 1, 4'd0, 1, 1);
    add(0, 0, 4'd0,  1, 1, 0, 4'd0, 0, 1);
    add(0, 1, 4'd5,  0, 1, 0, 4'd5, 0, 0);

    foreach (tbl[i]) begin
      rst           = tbl[i].rst;
      if_b.load     = tbl[i].load;
      if_b.load_val = tbl[i].load_val;
      if_b.en       = tbl[i].en;
      if_b.up       = tbl[i].up;
      if_b.oneshot  = tbl[i].oneshot;
      tick();
      chk($sformatf("m10[%0d].cnt", i), if_b.cnt, tbl[i].exp_cnt);
      chk($sformatf("m10[%0d].tc", i), if_b.tc, tbl[i].exp_tc);
      chk($sformatf("m10[%0d].done", i), if_b.done, tbl[i].exp_done);
    end
    rst = 1'b0;
    {if_b.en, if_b.load} = '0;

    // One-shot up from 14: stops at 15, ignores en/up in HALT, load restarts
    if_a.en = 1'b0;
    if_a.load = 1'b1;
    if_a.load_val = 4'd14;
    tick();
    if_a.load = 1'b0;
    if_a.en = 1'b1;
    if_a.up = 1'b1;
    if_a.oneshot = 1'b1;
    tick();
    chk("os.cnt15", if_a.cnt, 15);
    chk("os.pre_done", if_a.done, 0);
    tick();
    chk("os.hold_cnt", if_a.cnt, 15);
    chk("os.tc", if_a.tc, 1);
    chk("os.done", if_a.done, 1);
    tick();
    chk("os.tc_once", if_a.tc, 0);
    chk("os.still_done", if_a.done, 1);
    if_a.en = 1'b0;
    tick();
    if_a.en = 1'b1;
    if_a.up = 1'b0;
    if_a.oneshot = 1'b0;
    tick();
    chk("os.halt_cnt", if_a.cnt, 15);
    chk("os.halt_done", if_a.done, 1);
    chk("os.halt_tc", if_a.tc, 0);
    if_a.en = 1'b0;
    if_a.load = 1'b1;
    if_a.load_val = 4'd0;
    tick();
    chk("os.reload_cnt", if_a.cnt, 0);
    chk("os.reload_done", if_a.done, 0);
    if_a.load = 1'b0;
    if_a.en = 1'b1;
    if_a.up = 1'b1;
    tick();
    chk("os.resume_cnt", if_a.cnt, 1);

    // Prescaler: en low only in cycle 2; steps land on enabled cycles 3 and 6
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_p.up = 1'b1;
    e = 0;
    for (int c = 1; c <= 8; c++) begin
      if_p.en = (c != 2);
      if (c != 2) e++;
      tick();
      chk($sformatf("ps[c%0d].cnt", c), if_p.cnt, e / PS_EFF);
    end

    // Reset mid-count at 7 with load asserted; next interval must be full length
    if_p.en = 1'b0;
    if_p.load = 1'b1;
    if_p.load_val = 4'd5;
    tick();
    if_p.load = 1'b0;
    if_p.en = 1'b1;
    k = 0;
    while (if_p.cnt != 4'd7 && k < 40) begin
      tick();
      k++;
    end
    chk("mid.reach7", if_p.cnt, 7);
    if (PS_EFF > 1) tick();
    rst = 1'b1;
    if_p.load = 1'b1;
    if_p.load_val = 4'd3;
    tick();
    chk("mid.rst_cnt", if_p.cnt, 0);
    chk("mid.rst_tc", if_p.tc, 0);
    chk("mid.rst_done", if_p.done, 0);
    rst = 1'b0;
    if_p.load = 1'b0;
    for (int j = 1; j <= PS_EFF; j++) begin
      tick();
      chk($sformatf("mid.restart[%0d]", j), if_p.cnt, (j == PS_EFF) ? 1 : 0);
    end

    // Reset on the edge where a wrap from 15 would have raised tc
    if_a.en = 1'b0;
    if_a.oneshot = 1'b0;
    if_a.load = 1'b1;
    if_a.load_val = 4'd15;
    tick();
    if_a.load = 1'b0;
    if_a.en = 1'b1;
    if_a.up = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst_tc.cnt", if_a.cnt, 0);
    chk("rst_tc.tc", if_a.tc, 0);
    rst = 1'b0;
    tick();
    chk("rst_tc.after_cnt", if_a.cnt, 1);
    chk("rst_tc.after_tc", if_a.tc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
